// File: rtl/shift_engine.sv
// shift_engine
// ------------------------------------------------------------------------
// Parametrised serial shift engine. One WIDTH-bit register serves as the
// serialiser (parallel word out on BIT_OUT) and the deserialiser (serial
// DATA_IN into SHIFT_REG). A frame starts with an accepted parallel load
// and completes after exactly WIDTH enabled shifts.
//
// Handshake: a load transfers on a rising CLK edge where LOAD_VALID=1 and
// LOAD_READY=1. LOAD_READY is high only in IDLE. While a frame is running
// LOAD_VALID is ignored, so the requester simply keeps it asserted until
// it is accepted.
//
// Optional feature (macro SHIFT_ENGINE_CAPTURE_EN): adds RX_WORD/RX_VALID,
// a capture of the fully deserialised word taken on the final shift of
// each frame.
//
// Parameters:
//   WIDTH      register width (>= 2)
//   RESET_VAL  SHIFT_REG value on reset
//   MSB_FIRST  0: right shift, LSB out first; 1: left shift, MSB out first
//   CW         width of BIT_CNT (derived)
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   LOAD_VALID/READY  parallel-load handshake
//   LOAD_DATA         parallel word to load
//   SHIFT_EN          perform one shift this cycle
//   DATA_IN           serial input bit
//   BIT_OUT           serial output bit (combinational from SHIFT_REG)
//   SHIFT_REG         register contents
//   BIT_CNT           enabled shifts completed in the current frame
//   BUSY              frame in progress (FSM in SHIFT)
//   FRAME_DONE        one-cycle pulse after the final shift of a frame
//   RX_WORD/RX_VALID  captured word and its pulse (capture build only)
// ------------------------------------------------------------------------
module shift_engine #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'('h55),
    parameter bit               MSB_FIRST = 1'b0,
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             SHIFT_EN,
    input  logic             DATA_IN,
    output logic             BIT_OUT,
    output logic [WIDTH-1:0] SHIFT_REG,
    output logic [CW-1:0]    BIT_CNT,
    output logic             BUSY,
    output logic             FRAME_DONE
`ifdef SHIFT_ENGINE_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] RX_WORD,
    output logic             RX_VALID
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shifted;
    logic             last_shift;

    // Next register value for one shift in the configured direction.
    always_comb begin
        shifted = SHIFT_REG;
        if (MSB_FIRST) begin
            shifted = {SHIFT_REG[WIDTH-2:0], DATA_IN};
        end else begin
            shifted = {DATA_IN, SHIFT_REG[WIDTH-1:1]};
        end
    end

    // Final shift of a tracked frame; free-running shifts in IDLE never count.
    assign last_shift = (state == ST_SHIFT) && SHIFT_EN &&
                        (BIT_CNT == CW'(WIDTH - 1));

    assign BIT_OUT    = MSB_FIRST ? SHIFT_REG[WIDTH-1] : SHIFT_REG[0];
    assign LOAD_READY = (state == ST_IDLE);
    assign BUSY       = (state == ST_SHIFT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            SHIFT_REG  <= RESET_VAL;
            BIT_CNT    <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LOAD_VALID) begin
                        // Load has priority over a simultaneous shift request.
                        SHIFT_REG <= LOAD_DATA;
                        BIT_CNT   <= '0;
                        state     <= ST_SHIFT;
                    end else if (SHIFT_EN) begin
                        SHIFT_REG <= shifted;
                    end
                end
                ST_SHIFT: begin
                    if (SHIFT_EN) begin
                        SHIFT_REG <= shifted;
                        if (last_shift) begin
                            // Count saturates at WIDTH until the next load.
                            BIT_CNT    <= CW'(WIDTH);
                            FRAME_DONE <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            BIT_CNT <= BIT_CNT + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_ENGINE_CAPTURE_EN
    // Capture the post-shift word so RX_WORD is independent of later
    // free-running shifts or reloads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RX_WORD  <= '0;
            RX_VALID <= 1'b0;
        end else begin
            RX_VALID <= last_shift;
            if (last_shift) begin
                RX_WORD <= shifted;
            end
        end
    end
`endif

endmodule
